// File: rtl/p09_ball_mover_pkg.sv
// Shared definitions for the breakout ball mover: state encoding, screen
// geometry and the serve-position helper.
package p09_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        LOST  = 2'd2
    } state_t;

    localparam logic [9:0] SCREEN_W    = 10'd640;
    localparam logic [8:0] SCREEN_H    = 9'd480;
    localparam logic [9:0] BALL_SIZE   = 10'd5;
    localparam logic [8:0] PADDLE_Y    = 9'd440;
    localparam logic [9:0] PADDLE_W    = 10'd40;
    localparam logic [2:0] STEP        = 3'd1;
    localparam logic [7:0] LOST_FRAMES = 8'd60;

    // Largest on-screen top-left coordinates and the resting row on the paddle.
    localparam logic [9:0] X_MAX   = SCREEN_W - BALL_SIZE;
    localparam logic [8:0] Y_MAX   = SCREEN_H - BALL_SIZE[8:0];
    localparam logic [8:0] SERVE_Y = PADDLE_Y - BALL_SIZE[8:0];

    // Ball centred on the paddle; wraps at 10 bits like the position register.
    function automatic logic [9:0] serve_x(input logic [9:0] paddle_x);
        return paddle_x + (PADDLE_W >> 1) - 10'd2;
    endfunction

endpackage

// File: rtl/p09_ball_mover_if.sv
// Painter/playfield link of the ball mover: per-pixel edge and solid flags
// toward the mover, ball position and direction back toward the painter.
interface p09_ball_mover_if;
    logic       display_active;
    logic       in_ball_top;
    logic       in_ball_bottom;
    logic       in_ball_left;
    logic       in_ball_right;
    logic       solid;
    logic       paddle;
    logic [9:0] x;
    logic [8:0] y;
    logic       dir_x;
    logic       dir_y;

    modport master (
        output display_active, in_ball_top, in_ball_bottom, in_ball_left,
               in_ball_right, solid, paddle,
        input  x, y, dir_x, dir_y
    );

    modport slave (
        input  display_active, in_ball_top, in_ball_bottom, in_ball_left,
               in_ball_right, solid, paddle,
        output x, y, dir_x, dir_y
    );
endinterface

// File: rtl/p09_hit_latch.sv
// Sticky per-frame collision flags. Outputs include a hit arriving in the
// current cycle so a collision coinciding with frame_pulse is not lost.
// Optional paddle-hit flag built only with P09_BALL_SPEEDUP_EN.
module p09_hit_latch (
    input  logic clk,
    input  logic nRst,
    input  logic frame_pulse,
    input  logic display_active,
    input  logic solid,
    input  logic in_ball_top,
    input  logic in_ball_bottom,
    input  logic in_ball_left,
    input  logic in_ball_right,
    output logic hit_t,
    output logic hit_b,
    output logic hit_l,
    output logic hit_r
`ifdef P09_BALL_SPEEDUP_EN
    ,
    input  logic paddle,
    output logic hit_pad
`endif
);

    logic [3:0] set_s;
    logic [3:0] flag_r;

    assign set_s = {4{display_active & solid}} &
                   {in_ball_top, in_ball_bottom, in_ball_left, in_ball_right};

    // Accumulate edge hits over the frame; frame_pulse consumes and clears them.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)            flag_r <= 4'b0000;
        else if (frame_pulse) flag_r <= 4'b0000;
        else                  flag_r <= flag_r | set_s;
    end

    assign {hit_t, hit_b, hit_l, hit_r} = flag_r | set_s;

`ifdef P09_BALL_SPEEDUP_EN
    logic pad_set_s;
    logic pad_r;

    assign pad_set_s = display_active & solid & paddle & in_ball_bottom;

    // Paddle contact flag with the same frame-scoped lifetime as the edge flags.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)            pad_r <= 1'b0;
        else if (frame_pulse) pad_r <= 1'b0;
        else                  pad_r <= pad_r | pad_set_s;
    end

    assign hit_pad = pad_r | pad_set_s;
`endif

endmodule

// File: rtl/p09_ball_mover.sv
// Breakout ball motion controller: serve/play/lost sequencing, reflection
// and once-per-frame stepping of the ball's top-left position.
// Optional macro P09_BALL_SPEEDUP_EN doubles the step after 7 paddle-hit frames.
module p09_ball_mover
    import p09_pkg::*;
(
    input  logic             clk,
    input  logic             nRst,
    input  logic             frame_pulse,
    input  logic [9:0]       paddle_x,
    input  logic             launch,
    p09_ball_mover_if.slave  bus,
    output logic             ball_lost,
    output logic             playing
);

    state_t      state_r, state_s;
    logic [9:0]  x_r, x_s;
    logic [8:0]  y_r, y_s;
    logic        dir_x_r, dir_x_s, dir_y_r, dir_y_s;
    logic [7:0]  lost_cnt_r, lost_cnt_s;
    logic        ball_lost_r, ball_lost_s;
    logic        playing_r;
    logic        hit_t_s, hit_b_s, hit_l_s, hit_r_s;
    logic [3:0]  step_s;
    logic [10:0] x_sum_s;
    logic [9:0]  y_sum_s;
    logic        ndx_s, ndy_s;
`ifdef P09_BALL_SPEEDUP_EN
    logic        hit_pad_s;
    logic [2:0]  pad_cnt_r, pad_cnt_s;
`endif

    p09_hit_latch u_hit_latch (
        .clk            (clk),
        .nRst           (nRst),
        .frame_pulse    (frame_pulse),
        .display_active (bus.display_active),
        .solid          (bus.solid),
        .in_ball_top    (bus.in_ball_top),
        .in_ball_bottom (bus.in_ball_bottom),
        .in_ball_left   (bus.in_ball_left),
        .in_ball_right  (bus.in_ball_right),
        .hit_t          (hit_t_s),
        .hit_b          (hit_b_s),
        .hit_l          (hit_l_s),
        .hit_r          (hit_r_s)
`ifdef P09_BALL_SPEEDUP_EN
        ,
        .paddle         (bus.paddle),
        .hit_pad        (hit_pad_s)
`endif
    );

    // Effective per-axis step for this frame.
    always_comb begin
`ifdef P09_BALL_SPEEDUP_EN
        if (pad_cnt_r == 3'd7) step_s = {STEP, 1'b0};
        else                   step_s = {1'b0, STEP};
`else
        step_s = {1'b0, STEP};
`endif
    end

    // Next-state, reflection and movement; everything advances only on frame_pulse.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        y_s         = y_r;
        dir_x_s     = dir_x_r;
        dir_y_s     = dir_y_r;
        lost_cnt_s  = lost_cnt_r;
        ball_lost_s = 1'b0;
        ndx_s       = dir_x_r;
        ndy_s       = dir_y_r;
        x_sum_s     = {1'b0, x_r} + {7'd0, step_s};
        y_sum_s     = {1'b0, y_r} + {6'd0, step_s};
`ifdef P09_BALL_SPEEDUP_EN
        pad_cnt_s   = pad_cnt_r;
`endif
        if (frame_pulse) begin
            case (state_r)
                SERVE: begin
                    x_s = serve_x(paddle_x);
                    y_s = SERVE_Y;
                    if (launch) begin
                        state_s = PLAY;
                        dir_x_s = 1'b0;
                        dir_y_s = 1'b1;
                    end else begin
                        state_s = SERVE;
                    end
                end
                PLAY: begin
                    // Only hits opposing the travel direction reflect, so a ball
                    // still overlapping a solid is not bounced back into it.
                    if (hit_l_s && dir_x_r)        ndx_s = 1'b0;
                    else if (hit_r_s && !dir_x_r)  ndx_s = 1'b1;
                    else                           ndx_s = dir_x_r;
                    if (hit_t_s && dir_y_r)        ndy_s = 1'b0;
                    else if (hit_b_s && !dir_y_r)  ndy_s = 1'b1;
                    else                           ndy_s = dir_y_r;
                    dir_x_s = ndx_s;
                    dir_y_s = ndy_s;

                    if (ndx_s) begin
                        if (x_r < {6'd0, step_s}) begin
                            x_s     = 10'd0;
                            dir_x_s = 1'b0;
                        end else begin
                            x_s = x_r - {6'd0, step_s};
                        end
                    end else if (x_sum_s > {1'b0, X_MAX}) begin
                        x_s     = X_MAX;
                        dir_x_s = 1'b1;
                    end else begin
                        x_s = x_sum_s[9:0];
                    end

                    if (ndy_s) begin
                        if (y_r < {5'd0, step_s}) begin
                            y_s     = 9'd0;
                            dir_y_s = 1'b0;
                        end else begin
                            y_s = y_r - {5'd0, step_s};
                        end
                    end else if (y_sum_s > {1'b0, Y_MAX}) begin
                        // Ball leaves through the bottom: keep its last visible spot.
                        state_s     = LOST;
                        ball_lost_s = 1'b1;
                        lost_cnt_s  = 8'd0;
                        x_s         = x_r;
                        y_s         = y_r;
                    end else begin
                        y_s = y_sum_s[8:0];
                    end
`ifdef P09_BALL_SPEEDUP_EN
                    if (hit_pad_s && (pad_cnt_r != 3'd7)) pad_cnt_s = pad_cnt_r + 3'd1;
                    else                                  pad_cnt_s = pad_cnt_r;
`endif
                end
                LOST: begin
                    if (lost_cnt_r == (LOST_FRAMES - 8'd1)) begin
                        state_s = SERVE;
                        x_s     = serve_x(paddle_x);
                        y_s     = SERVE_Y;
`ifdef P09_BALL_SPEEDUP_EN
                        pad_cnt_s = 3'd0;
`endif
                    end else begin
                        lost_cnt_s = lost_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_s = SERVE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, position and status registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r     <= SERVE;
            x_r         <= serve_x(10'd0);
            y_r         <= SERVE_Y;
            dir_x_r     <= 1'b0;
            dir_y_r     <= 1'b1;
            lost_cnt_r  <= 8'd0;
            ball_lost_r <= 1'b0;
            playing_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            dir_x_r     <= dir_x_s;
            dir_y_r     <= dir_y_s;
            lost_cnt_r  <= lost_cnt_s;
            ball_lost_r <= ball_lost_s;
            playing_r   <= (state_s == PLAY);
        end
    end

`ifdef P09_BALL_SPEEDUP_EN
    // Paddle-hit frame counter that unlocks the faster step.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) pad_cnt_r <= 3'd0;
        else       pad_cnt_r <= pad_cnt_s;
    end
`endif

    assign bus.x     = x_r;
    assign bus.y     = y_r;
    assign bus.dir_x = dir_x_r;
    assign bus.dir_y = dir_y_r;
    assign ball_lost = ball_lost_r;
    assign playing   = playing_r;

endmodule

// File: tb/tb_p09_ball_mover.sv
// Directed bench for p09_ball_mover. Each frame is three clocks: an optional
// hit cycle, then the frame_pulse cycle; outputs are sampled on falling edges.
module tb_p09_ball_mover;

    localparam logic [3:0] H_NONE = 4'b0000;
    localparam logic [3:0] H_TOP  = 4'b1000;
    localparam logic [3:0] H_BOT  = 4'b0100;
    localparam logic [3:0] H_LR   = 4'b0011;

    logic       clk;
    logic       nRst;
    logic       frame_pulse;
    logic [9:0] paddle_x;
    logic       launch;
    logic       ball_lost;
    logic       playing;
    int         checks;
    int         errors;
    logic [9:0] frz_x;
    logic [8:0] frz_y;

    p09_ball_mover_if bus ();

    p09_ball_mover dut (
        .clk         (clk),
        .nRst        (nRst),
        .frame_pulse (frame_pulse),
        .paddle_x    (paddle_x),
        .launch      (launch),
        .bus         (bus),
        .ball_lost   (ball_lost),
        .playing     (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_hits(input logic [3:0] h, input logic act, input logic pad);
        bus.display_active = act;
        bus.solid          = |h;
        bus.in_ball_top    = h[3];
        bus.in_ball_bottom = h[2];
        bus.in_ball_left   = h[1];
        bus.in_ball_right  = h[0];
        bus.paddle         = pad;
    endtask

    // One frame; 'same' places the hit in the frame_pulse cycle itself.
    task automatic frame(input logic [3:0] h, input logic act, input logic pad, input logic same);
        @(negedge clk);
        if (same) begin
            frame_pulse = 1'b1;
            drive_hits(h, act, pad);
        end else begin
            drive_hits(h, act, pad);
            @(negedge clk);
            drive_hits(H_NONE, 1'b0, 1'b0);
            frame_pulse = 1'b1;
        end
        @(negedge clk);
        frame_pulse = 1'b0;
        drive_hits(H_NONE, 1'b0, 1'b0);
    endtask

    task automatic idle_frame();
        frame(H_NONE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        nRst = 1'b0; frame_pulse = 1'b0; launch = 1'b0; paddle_x = 10'd100;
        drive_hits(H_NONE, 1'b0, 1'b0);
        #12;
        checks++; if (bus.x !== 10'd18) begin errors++; $display("FAIL reset_x: got %0d expected 18", bus.x); end
        checks++; if (bus.y !== 9'd435) begin errors++; $display("FAIL reset_y: got %0d expected 435", bus.y); end
        checks++; if (bus.dir_x !== 1'b0 || bus.dir_y !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b%b expected 01", bus.dir_x, bus.dir_y); end
        checks++; if (playing !== 1'b0 || ball_lost !== 1'b0) begin errors++; $display("FAIL reset_flags: got playing=%b lost=%b expected 0 0", playing, ball_lost); end
        @(negedge clk); nRst = 1'b1;
        for (int i = 0; i < 3; i++) idle_frame();
        checks++; if (bus.x !== 10'd118 || bus.y !== 9'd435) begin errors++; $display("FAIL serve_pos: got %0d,%0d expected 118,435", bus.x, bus.y); end
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL serve_playing: got %b expected 0", playing); end
    endtask

    task automatic test_launch();
        launch = 1'b1;
        idle_frame();
        launch = 1'b0;
        checks++; if (playing !== 1'b1) begin errors++; $display("FAIL launch_playing: got %b expected 1", playing); end
        checks++; if (bus.x !== 10'd118 || bus.y !== 9'd435) begin errors++; $display("FAIL launch_pos: got %0d,%0d expected 118,435", bus.x, bus.y); end
        for (int i = 0; i < 10; i++) idle_frame();
        checks++; if (bus.x !== 10'd128 || bus.y !== 9'd425) begin errors++; $display("FAIL play_pos: got %0d,%0d expected 128,425", bus.x, bus.y); end
        checks++; if (bus.dir_x !== 1'b0 || bus.dir_y !== 1'b1) begin errors++; $display("FAIL play_dir: got %b%b expected 01", bus.dir_x, bus.dir_y); end
    endtask

    task automatic test_top_hit();
        frame(H_TOP, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.dir_y !== 1'b0 || bus.y !== 9'd426 || bus.x !== 10'd129) begin errors++; $display("FAIL top_reflect: got dir_y=%b y=%0d x=%0d expected 0 426 129", bus.dir_y, bus.y, bus.x); end
        frame(H_TOP, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.dir_y !== 1'b0 || bus.y !== 9'd427) begin errors++; $display("FAIL top_repeat: got dir_y=%b y=%0d expected 0 427", bus.dir_y, bus.y); end
        frame(H_BOT, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.dir_y !== 1'b0 || bus.y !== 9'd428) begin errors++; $display("FAIL blank_hit: got dir_y=%b y=%0d expected 0 428", bus.dir_y, bus.y); end
        frame(H_BOT, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.dir_y !== 1'b1 || bus.y !== 9'd427 || bus.x !== 10'd132) begin errors++; $display("FAIL pulse_cycle_hit: got dir_y=%b y=%0d x=%0d expected 1 427 132", bus.dir_y, bus.y, bus.x); end
        idle_frame();
        checks++; if (bus.dir_y !== 1'b1 || bus.y !== 9'd426 || bus.x !== 10'd133) begin errors++; $display("FAIL hit_cleared: got dir_y=%b y=%0d x=%0d expected 1 426 133", bus.dir_y, bus.y, bus.x); end
    endtask

    task automatic test_opposite_x();
        frame(H_LR, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.dir_x !== 1'b1 || bus.x !== 10'd132 || bus.y !== 9'd425) begin errors++; $display("FAIL lr_first: got dir_x=%b x=%0d y=%0d expected 1 132 425", bus.dir_x, bus.x, bus.y); end
        frame(H_LR, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.dir_x !== 1'b0 || bus.x !== 10'd133 || bus.y !== 9'd424) begin errors++; $display("FAIL lr_second: got dir_x=%b x=%0d y=%0d expected 0 133 424", bus.dir_x, bus.x, bus.y); end
    endtask

    task automatic test_wall_clamp();
        for (int k = 1; k <= 501; k++) begin
            idle_frame();
            if (k == 424) begin
                checks++; if (bus.y !== 9'd0 || bus.dir_y !== 1'b1) begin errors++; $display("FAIL top_reach: got y=%0d dir_y=%b expected 0 1", bus.y, bus.dir_y); end
            end
            if (k == 425) begin
                checks++; if (bus.y !== 9'd0 || bus.dir_y !== 1'b0 || bus.x !== 10'd558) begin errors++; $display("FAIL top_clamp: got y=%0d dir_y=%b x=%0d expected 0 0 558", bus.y, bus.dir_y, bus.x); end
            end
        end
        checks++; if (bus.x !== 10'd634 || bus.y !== 9'd76 || bus.dir_x !== 1'b0) begin errors++; $display("FAIL near_wall: got x=%0d y=%0d dir_x=%b expected 634 76 0", bus.x, bus.y, bus.dir_x); end
        idle_frame();
        checks++; if (bus.x !== 10'd635 || bus.dir_x !== 1'b0) begin errors++; $display("FAIL wall_edge: got x=%0d dir_x=%b expected 635 0", bus.x, bus.dir_x); end
        idle_frame();
        checks++; if (bus.x !== 10'd635 || bus.dir_x !== 1'b1 || bus.y !== 9'd78) begin errors++; $display("FAIL wall_clamp: got x=%0d dir_x=%b y=%0d expected 635 1 78", bus.x, bus.dir_x, bus.y); end
    endtask

    task automatic test_ball_lost();
        for (int k = 0; k < 397; k++) idle_frame();
        checks++; if (bus.x !== 10'd238 || bus.y !== 9'd475 || bus.dir_y !== 1'b0) begin errors++; $display("FAIL bottom_reach: got x=%0d y=%0d dir_y=%b expected 238 475 0", bus.x, bus.y, bus.dir_y); end
        idle_frame();
        checks++; if (ball_lost !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL lost_pulse: got lost=%b playing=%b expected 1 0", ball_lost, playing); end
        frz_x = bus.x;
        frz_y = bus.y;
        checks++; if (frz_x !== 10'd238 || frz_y !== 9'd475) begin errors++; $display("FAIL lost_pos: got %0d,%0d expected 238,475", frz_x, frz_y); end
        @(negedge clk);
        checks++; if (ball_lost !== 1'b0) begin errors++; $display("FAIL lost_width: got %b expected 0", ball_lost); end
        launch = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            idle_frame();
            checks++; if (playing !== 1'b0 || ball_lost !== 1'b0 || bus.x !== frz_x || bus.y !== frz_y) begin
                errors++; $display("FAIL lost_hold[%0d]: got playing=%b lost=%b pos=%0d,%0d expected 0 0 %0d,%0d", k, playing, ball_lost, bus.x, bus.y, frz_x, frz_y);
            end
        end
        idle_frame();
        checks++; if (playing !== 1'b0) begin errors++; $display("FAIL lost_exit: got playing=%b expected 0", playing); end
        idle_frame();
        launch = 1'b0;
        checks++; if (playing !== 1'b1 || bus.x !== 10'd118 || bus.y !== 9'd435 || bus.dir_y !== 1'b1 || bus.dir_x !== 1'b0) begin
            errors++; $display("FAIL relaunch: got playing=%b pos=%0d,%0d dir=%b%b expected 1 118,435 01", playing, bus.x, bus.y, bus.dir_x, bus.dir_y);
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k < 3; k++) idle_frame();
        @(negedge clk);
        drive_hits(H_TOP, 1'b1, 1'b0);
        #2 nRst = 1'b0;
        #1;
        checks++; if (bus.x !== 10'd18 || bus.y !== 9'd435 || playing !== 1'b0 || bus.dir_y !== 1'b1 || bus.dir_x !== 1'b0) begin
            errors++; $display("FAIL midframe_reset: got pos=%0d,%0d playing=%b dir=%b%b expected 18,435 0 01", bus.x, bus.y, playing, bus.dir_x, bus.dir_y);
        end
        @(negedge clk);
        nRst = 1'b1;
        drive_hits(H_NONE, 1'b0, 1'b0);
        idle_frame();
        checks++; if (bus.x !== 10'd118 || playing !== 1'b0) begin errors++; $display("FAIL post_reset_serve: got x=%0d playing=%b expected 118 0", bus.x, playing); end
    endtask

`ifdef P09_BALL_SPEEDUP_EN
    task automatic test_speedup();
        launch = 1'b1;
        idle_frame();
        launch = 1'b0;
        for (int k = 0; k < 7; k++) frame(H_BOT, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.y !== 9'd428 || bus.x !== 10'd125) begin errors++; $display("FAIL speed_before: got %0d,%0d expected 125,428", bus.x, bus.y); end
        idle_frame();
        checks++; if (bus.y !== 9'd426 || bus.x !== 10'd127) begin errors++; $display("FAIL speed_after: got %0d,%0d expected 127,426", bus.x, bus.y); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_launch();
        test_top_hit();
        test_opposite_x();
        test_wall_clamp();
        test_ball_lost();
        test_reset_midframe();
`ifdef P09_BALL_SPEEDUP_EN
        test_speedup();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/p09_ball_mover.md
Name: p09_ball_mover

Overview:
Ball motion controller for the breakout game, directly upstream of the ball painter. It produces the ball's top-left position (x, y) that the painter draws. It consumes the painter's per-pixel edge-region flags, qualified by a "solid" pixel indication from the playfield (walls, bricks, paddle). It accumulates collisions over a frame, reflects the direction, and steps the position once per frame. It also handles serve, play and ball-lost sequencing.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 5, ball extent in both axes, matching the painter's 5x5 sprite
PADDLE_Y, 440, paddle top row; on serve, ball y = PADDLE_Y - BALL_SIZE
PADDLE_W, 40, paddle width; on serve, ball x = paddle_x + PADDLE_W/2 - 2
STEP, 1, pixels moved per frame on each axis (3 bits)
LOST_FRAMES, 60, frames spent in LOST before returning to SERVE (8 bits)

Ports:
clk  in  1  pixel clock
nRst  in  1  asynchronous active-low reset
frame_pulse  in  1  one-cycle pulse at the start of vertical blanking
display_active  in  1  high during visible pixels
in_ball_top  in  1  painter top edge region
in_ball_bottom  in  1  painter bottom edge region
in_ball_left  in  1  painter left edge region
in_ball_right  in  1  painter right edge region
solid  in  1  current pixel is wall, brick or paddle
paddle  in  1  current pixel is paddle
paddle_x  in  10  paddle left x
launch  in  1  serve button, level-sensitive
x  out  10  ball left x
y  out  9  ball top y
dir_x  out  1  0 = right (+x), 1 = left (-x)
dir_y  out  1  0 = down (+y), 1 = up (-y)
ball_lost  out  1  one-cycle pulse when the ball exits the bottom of the screen
playing  out  1  high in PLAY

Behaviour:
- Reset is asynchronous on nRst (active low); clock is clk. Reset values:
  - state = SERVE; x = serve x computed from paddle_x = 0; y = PADDLE_Y - BALL_SIZE.
  - dir_x = 0, dir_y = 1; ball_lost = 0; playing = 0.
  - All hit flags, lost counter and paddle-hit counter = 0.
- Hit flags hit_t, hit_b, hit_l, hit_r:
  - Each is set on any cycle where display_active && solid && in_ball_<edge>.
  - All four are sticky until frame_pulse.
  - hit_pad is set on any hit with paddle=1 and in_ball_bottom.
- On frame_pulse, all hit flags are sampled, including a hit asserted in that same cycle, and then cleared. All state updates below occur only on frame_pulse.
- SERVE:
  - x = paddle_x + PADDLE_W/2 - 2 (10-bit truncation); y = PADDLE_Y - BALL_SIZE.
  - If launch=1: go to PLAY with dir_y=1 (up) and dir_x=0 (right).
- PLAY:
  - Reflection, evaluated first:
    - hit_t && dir_y=1 -> dir_y=0.
    - hit_b && dir_y=0 -> dir_y=1.
    - hit_l && dir_x=1 -> dir_x=0.
    - hit_r && dir_x=0 -> dir_x=1.
    - Hits against the current direction of travel are ignored. This avoids re-reflection while the ball is still overlapping a solid.
    - Opposite hits on the same axis in the same frame: the rule above still applies per flag, so at most one of them can change that axis.
  - Then move by STEP per axis in the new direction.
  - Clamp in x: if x - STEP would underflow, set x = 0 and dir_x = 0. If x + STEP > SCREEN_W - BALL_SIZE, set x = SCREEN_W - BALL_SIZE and dir_x = 1.
  - Clamp at top: if moving up with y < STEP, set y = 0 and dir_y = 0.
  - If moving down and the new y > SCREEN_H - BALL_SIZE: go to LOST, pulse ball_lost for 1 cycle, and reset the lost counter to 0.
- LOST:
  - Position is frozen; the counter increments per frame_pulse.
  - When it reaches LOST_FRAMES - 1, go to SERVE.
  - launch is ignored in this state.
- playing = (state == PLAY), registered.
- x and y are registered and change only in the cycle after frame_pulse, so they are stable for the whole visible frame.
- nRst asserted mid-frame returns all state to reset values immediately.

Optional Feature:
- Macro P09_BALL_SPEEDUP_EN.
- When defined:
  - A 3-bit counter counts frames with hit_pad in PLAY.
  - When it saturates at 7, the effective step becomes 2*STEP.
  - The counter clears on entry to SERVE.
- When undefined: the step is always STEP, and hit_pad and its counter are not synthesized.

Decomposition:
- Shared package p09_pkg holds:
  - The state encoding SERVE=2'd0, PLAY=2'd1, LOST=2'd2.
  - The screen geometry constants SCREEN_W, SCREEN_H, BALL_SIZE, PADDLE_Y and PADDLE_W.
- One sub-module is natural: p09_hit_latch, which holds the four sticky edge flags plus hit_pad with the frame_pulse clear.
- Axis update stays inline.

Test Plan:
- Reset, paddle_x=100, 3 frames -> SERVE, x=118, y=435, playing=0.
- launch=1 at frame_pulse, then 10 frames with no hits -> PLAY, x=128, y=425, dir_x=0, dir_y=1.
- Inject solid && in_ball_top during the visible area of one frame while moving up -> after the next frame_pulse, dir_y=0 and y increases by 1. Repeating the top hit on the following frame does not flip dir_y.
- In PLAY with x=634, moving right, no hits -> x clamps to 635, dir_x=1. Same frame with hit_l and hit_r both asserted -> dir_x changes once only.
- Ball moving down at y=475 -> next frame ball_lost pulses for exactly 1 cycle; then 60 frames in LOST with position frozen and launch ignored; then SERVE.
- With P09_BALL_SPEEDUP_EN: 7 paddle-hit frames -> per-frame displacement changes from 1 to 2. On serve, it returns to 1.
